// File: rtl/reg_file_ctrl.sv
// -----------------------------------------------------------------------------
// reg_file_ctrl
//
// Command sequencer for a 4x8 register file with a registered read port.
// It accepts WRITE / READ / MOVE / SWAP commands over a valid/ready handshake,
// steps through the register-file cycles each one needs, and hides the file's
// one-cycle read latency from the requester. READ results come back on a
// valid/ready response channel that holds until the consumer takes them.
//
// Ports
//   CLK, RSTN       clock, asynchronous active-low reset
//   CMD_VALID       in   command valid
//   CMD_READY       out  controller idle and able to accept a command
//   CMD_OP          in   00 WRITE, 01 READ, 10 MOVE, 11 SWAP
//   CMD_DST         in   destination register (WRITE / MOVE / SWAP)
//   CMD_SRC         in   source register (READ / MOVE / SWAP)
//   CMD_DATA        in   write data (WRITE only)
//   RSP_VALID       out  read data valid
//   RSP_READY       in   consumer accepts read data
//   RSP_DATA        out  read data
//   RF_ADDR         out  register file address (holds outside access states)
//   RF_CE           out  register file write strobes, one-hot or zero
//   RF_DATA_IN      out  register file write data
//   RF_DATA_OUT     in   register file registered read data
//   BUSY            out  high whenever the sequencer is not idle
//
// Sequences (cycle 1 is the cycle after the accept edge, one state per cycle)
//   WRITE : WR                                  -> IDLE
//   READ  : RD_A -> RD_W -> RSP (until taken)   -> IDLE
//   MOVE  : RD_A -> RD_W -> WR                  -> IDLE
//   SWAP  : RD_A -> RD_B -> RD_W -> WR1 -> WR2  -> IDLE
// -----------------------------------------------------------------------------
module reg_file_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     CMD_VALID,
    output logic                     CMD_READY,
    input  logic [1:0]               CMD_OP,
    input  logic [ADDR_W-1:0]        CMD_DST,
    input  logic [ADDR_W-1:0]        CMD_SRC,
    input  logic [DATA_W-1:0]        CMD_DATA,
    output logic                     RSP_VALID,
    input  logic                     RSP_READY,
    output logic [DATA_W-1:0]        RSP_DATA,
    output logic [ADDR_W-1:0]        RF_ADDR,
    output logic [(2**ADDR_W)-1:0]   RF_CE,
    output logic [DATA_W-1:0]        RF_DATA_IN,
    input  logic [DATA_W-1:0]        RF_DATA_OUT,
    output logic                     BUSY
);

    localparam int NREG = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_MOVE  = 2'b10,
        OP_SWAP  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,     // single write: WRITE c1, MOVE c3
        S_RD_A,   // address the source register
        S_RD_B,   // SWAP only: address destination, source data arrives
        S_RD_W,   // last read data arrives from the file
        S_WR1,    // SWAP: destination <= old source
        S_WR2,    // SWAP: source <= old destination
        S_RSP     // READ: hold response until taken
    } state_t;

    state_t              state;
    op_t                 op_q;
    logic [ADDR_W-1:0]   dst_q;
    logic [ADDR_W-1:0]   src_q;
    logic [DATA_W-1:0]   tmp_a;   // first value read (source)
    logic [DATA_W-1:0]   tmp_b;   // second value read (SWAP destination)

    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // All outputs are registered: each state is entered with the RF_* values
    // that belong to it already set up, so the file sees clean, glitch-free
    // address/strobe/data for the whole cycle.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= S_IDLE;
            op_q       <= OP_WRITE;
            dst_q      <= '0;
            src_q      <= '0;
            tmp_a      <= '0;
            tmp_b      <= '0;
            CMD_READY  <= 1'b1;
            RSP_VALID  <= 1'b0;
            RSP_DATA   <= '0;
            RF_ADDR    <= '0;
            RF_CE      <= '0;
            RF_DATA_IN <= '0;
            BUSY       <= 1'b0;
        end else begin
            // NOTE: every state register here uses <= so all of them update
            // together from the values present before the edge; a blocking
            // assignment would leak a new value into later reads in this block.
            case (state)
                S_IDLE: begin
                    // CMD_READY is high exactly in IDLE, so VALID alone is the accept.
                    if (CMD_VALID) begin
                        op_q      <= op_t'(CMD_OP);
                        dst_q     <= CMD_DST;
                        src_q     <= CMD_SRC;
                        CMD_READY <= 1'b0;
                        BUSY      <= 1'b1;
                        if (op_t'(CMD_OP) == OP_WRITE) begin
                            state      <= S_WR;
                            RF_ADDR    <= CMD_DST;
                            RF_CE      <= onehot(CMD_DST);
                            RF_DATA_IN <= CMD_DATA;
                        end else begin
                            state   <= S_RD_A;
                            RF_ADDR <= CMD_SRC;
                        end
                    end
                end

                S_RD_A: begin
                    // Source data appears on RF_DATA_OUT during the next cycle.
                    if (op_q == OP_SWAP) begin
                        state   <= S_RD_B;
                        RF_ADDR <= dst_q;
                    end else begin
                        state <= S_RD_W;
                    end
                end

                S_RD_B: begin
                    tmp_a <= RF_DATA_OUT;          // source value
                    state <= S_RD_W;
                end

                S_RD_W: begin
                    case (op_q)
                        OP_READ: begin
                            RSP_DATA  <= RF_DATA_OUT;
                            RSP_VALID <= 1'b1;
                            state     <= S_RSP;
                        end
                        OP_MOVE: begin
                            // tmp_a and RF_DATA_IN take the same value; driving
                            // the file straight from the read port saves a cycle.
                            tmp_a      <= RF_DATA_OUT;
                            state      <= S_WR;
                            RF_ADDR    <= dst_q;
                            RF_CE      <= onehot(dst_q);
                            RF_DATA_IN <= RF_DATA_OUT;
                        end
                        default: begin         // OP_SWAP
                            tmp_b      <= RF_DATA_OUT;  // destination value
                            state      <= S_WR1;
                            RF_ADDR    <= dst_q;
                            RF_CE      <= onehot(dst_q);
                            RF_DATA_IN <= tmp_a;
                        end
                    endcase
                end

                S_WR1: begin
                    state      <= S_WR2;
                    RF_ADDR    <= src_q;
                    RF_CE      <= onehot(src_q);
                    RF_DATA_IN <= tmp_b;
                end

                S_RSP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        state     <= S_IDLE;
                        CMD_READY <= 1'b1;
                        BUSY      <= 1'b0;
                    end
                end

                // NOTE: the default arm covers S_WR, S_WR2 and any unreachable
                // encoding, so every path returns to a known idle state.
                default: begin
                    state     <= S_IDLE;
                    RF_CE     <= '0;
                    CMD_READY <= 1'b1;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_file_ctrl
//
// Bench for reg_file_ctrl paired with a behavioural 4x8 register file that has
// a registered read port. A plain array (model_regs) holds the architectural
// register contents; each command updates it by its meaning (write, copy,
// exchange) and the bench derives every expected RF_* / response value from it.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_reg_file_ctrl;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_SWAP  = 2'b11;

    logic       CLK;
    logic       RSTN;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [1:0] CMD_OP;
    logic [1:0] CMD_DST;
    logic [1:0] CMD_SRC;
    logic [7:0] CMD_DATA;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [7:0] RSP_DATA;
    logic [1:0] RF_ADDR;
    logic [3:0] RF_CE;
    logic [7:0] RF_DATA_IN;
    logic [7:0] RF_DATA_OUT;
    logic       BUSY;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] model_regs [4];

    reg_file_ctrl #(.DATA_W(8), .ADDR_W(2)) dut (
        .CLK         (CLK),
        .RSTN        (RSTN),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_OP      (CMD_OP),
        .CMD_DST     (CMD_DST),
        .CMD_SRC     (CMD_SRC),
        .CMD_DATA    (CMD_DATA),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_DATA    (RSP_DATA),
        .RF_ADDR     (RF_ADDR),
        .RF_CE       (RF_CE),
        .RF_DATA_IN  (RF_DATA_IN),
        .RF_DATA_OUT (RF_DATA_OUT),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Register file: writes on CE, read data registered from ADDR. No reset,
    // so contents survive a controller reset.
    logic [7:0] rf_mem [4];
    always @(posedge CLK) begin
        for (int i = 0; i < 4; i++)
            if (RF_CE[i]) rf_mem[i] <= RF_DATA_IN;
        RF_DATA_OUT <= rf_mem[RF_ADDR];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    // Present a command at a falling edge and return at the falling edge of c1.
    task automatic issue(input logic [1:0] op, input logic [1:0] dst,
                         input logic [1:0] src, input logic [7:0] data);
        int n;
        n = 0;
        CMD_OP = op; CMD_DST = dst; CMD_SRC = src; CMD_DATA = data;
        CMD_VALID = 1'b1;
        while (CMD_READY !== 1'b1 && n < 50) begin
            @(negedge CLK);
            n++;
        end
        n_vec++; if (CMD_READY !== 1'b1) begin n_err++; $display("FAIL accept_timeout: CMD_READY=%b expected 1", CMD_READY); end
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] dst, input logic [7:0] data);
        logic [3:0] e_ce;
        e_ce = 4'b0001 << dst;
        issue(OP_WRITE, dst, 2'd0, data);
        n_vec++; if (RF_CE !== e_ce)      begin n_err++; $display("FAIL wr_c1_ce: got %b expected %b", RF_CE, e_ce); end
        n_vec++; if (RF_ADDR !== dst)     begin n_err++; $display("FAIL wr_c1_addr: got %0d expected %0d", RF_ADDR, dst); end
        n_vec++; if (RF_DATA_IN !== data) begin n_err++; $display("FAIL wr_c1_data: got %h expected %h", RF_DATA_IN, data); end
        n_vec++; if (BUSY !== 1'b1 || CMD_READY !== 1'b0) begin n_err++; $display("FAIL wr_c1_busy_ready: got %b%b expected 10", BUSY, CMD_READY); end
        @(negedge CLK);
        n_vec++; if (RF_CE !== 4'b0000)   begin n_err++; $display("FAIL wr_c2_ce: got %b expected 0000", RF_CE); end
        n_vec++; if (CMD_READY !== 1'b1 || BUSY !== 1'b0) begin n_err++; $display("FAIL wr_c2_ready_busy: got %b%b expected 10", CMD_READY, BUSY); end
        model_regs[dst] = data;
    endtask

    // hold = number of extra cycles RSP_READY stays low while RSP_VALID is up.
    // With hold==0, RSP_READY is high from before the accept, which also shows
    // that it is ignored while no response is pending.
    task automatic do_read(input logic [1:0] src, input int hold);
        logic [7:0] exp_d;
        exp_d = model_regs[src];
        RSP_READY = (hold == 0);
        issue(OP_READ, 2'd0, src, 8'h00);
        n_vec++; if (RF_ADDR !== src)     begin n_err++; $display("FAIL rd_c1_addr: got %0d expected %0d", RF_ADDR, src); end
        n_vec++; if (RF_CE !== 4'b0000 || RSP_VALID !== 1'b0) begin n_err++; $display("FAIL rd_c1_ce_valid: got %b/%b expected 0000/0", RF_CE, RSP_VALID); end
        @(negedge CLK);
        n_vec++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b1) begin n_err++; $display("FAIL rd_c2_valid_busy: got %b%b expected 01", RSP_VALID, BUSY); end
        @(negedge CLK);
        n_vec++; if (RSP_VALID !== 1'b1)  begin n_err++; $display("FAIL rd_c3_valid: got %b expected 1", RSP_VALID); end
        n_vec++; if (RSP_DATA !== exp_d)  begin n_err++; $display("FAIL rd_c3_data r%0d: got %h expected %h", src, RSP_DATA, exp_d); end
        n_vec++; if (CMD_READY !== 1'b0)  begin n_err++; $display("FAIL rd_c3_ready: got %b expected 0", CMD_READY); end
        for (int k = 0; k < hold; k++) begin
            @(negedge CLK);
            n_vec++; if (RSP_VALID !== 1'b1 || RSP_DATA !== exp_d) begin n_err++; $display("FAIL rd_hold%0d: got %b/%h expected 1/%h", k, RSP_VALID, RSP_DATA, exp_d); end
            n_vec++; if (CMD_READY !== 1'b0 || BUSY !== 1'b1) begin n_err++; $display("FAIL rd_hold_ready_busy%0d: got %b%b expected 01", k, CMD_READY, BUSY); end
        end
        RSP_READY = 1'b1;
        @(negedge CLK);
        n_vec++; if (RSP_VALID !== 1'b0 || CMD_READY !== 1'b1 || BUSY !== 1'b0) begin n_err++; $display("FAIL rd_done: got valid/ready/busy %b%b%b expected 010", RSP_VALID, CMD_READY, BUSY); end
        RSP_READY = 1'b0;
    endtask

    task automatic do_move(input logic [1:0] src, input logic [1:0] dst);
        logic [7:0] v;
        logic [3:0] e_ce;
        v    = model_regs[src];
        e_ce = 4'b0001 << dst;
        issue(OP_MOVE, dst, src, 8'h00);
        n_vec++; if (RF_ADDR !== src || RF_CE !== 4'b0000) begin n_err++; $display("FAIL mv_c1: got addr %0d ce %b expected %0d 0000", RF_ADDR, RF_CE, src); end
        @(negedge CLK);
        n_vec++; if (RF_CE !== 4'b0000)   begin n_err++; $display("FAIL mv_c2_ce: got %b expected 0000", RF_CE); end
        @(negedge CLK);
        n_vec++; if (RF_CE !== e_ce)      begin n_err++; $display("FAIL mv_c3_ce: got %b expected %b", RF_CE, e_ce); end
        n_vec++; if (RF_ADDR !== dst || RF_DATA_IN !== v) begin n_err++; $display("FAIL mv_c3_addr_data: got %0d %h expected %0d %h", RF_ADDR, RF_DATA_IN, dst, v); end
        @(negedge CLK);
        n_vec++; if (RF_CE !== 4'b0000 || CMD_READY !== 1'b1 || BUSY !== 1'b0) begin n_err++; $display("FAIL mv_c4: got ce %b ready %b busy %b expected 0000 1 0", RF_CE, CMD_READY, BUSY); end
        model_regs[dst] = v;
    endtask

    // With abort set, returns at the falling edge of c5 (WR2) for a reset test.
    task automatic do_swap(input logic [1:0] src, input logic [1:0] dst, input bit abort);
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] ce_d;
        logic [3:0] ce_s;
        a = model_regs[src];
        b = model_regs[dst];
        ce_d = 4'b0001 << dst;
        ce_s = 4'b0001 << src;
        issue(OP_SWAP, dst, src, 8'h00);
        n_vec++; if (RF_ADDR !== src || RF_CE !== 4'b0000) begin n_err++; $display("FAIL sw_c1: got addr %0d ce %b expected %0d 0000", RF_ADDR, RF_CE, src); end
        @(negedge CLK);
        n_vec++; if (RF_ADDR !== dst || RF_CE !== 4'b0000) begin n_err++; $display("FAIL sw_c2: got addr %0d ce %b expected %0d 0000", RF_ADDR, RF_CE, dst); end
        @(negedge CLK);
        n_vec++; if (RF_CE !== 4'b0000)   begin n_err++; $display("FAIL sw_c3_ce: got %b expected 0000", RF_CE); end
        @(negedge CLK);
        n_vec++; if (RF_CE !== ce_d || RF_ADDR !== dst || RF_DATA_IN !== a) begin n_err++; $display("FAIL sw_c4: got ce %b addr %0d data %h expected %b %0d %h", RF_CE, RF_ADDR, RF_DATA_IN, ce_d, dst, a); end
        @(negedge CLK);
        n_vec++; if (RF_CE !== ce_s || RF_ADDR !== src || RF_DATA_IN !== b) begin n_err++; $display("FAIL sw_c5: got ce %b addr %0d data %h expected %b %0d %h", RF_CE, RF_ADDR, RF_DATA_IN, ce_s, src, b); end
        model_regs[dst] = a;
        if (!abort) begin
            @(negedge CLK);
            n_vec++; if (RF_CE !== 4'b0000 || CMD_READY !== 1'b1 || BUSY !== 1'b0) begin n_err++; $display("FAIL sw_c6: got ce %b ready %b busy %b expected 0000 1 0", RF_CE, CMD_READY, BUSY); end
            model_regs[src] = b;
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0; CMD_VALID = 1'b0; CMD_OP = 2'd0; CMD_DST = 2'd0; CMD_SRC = 2'd0;
        CMD_DATA = 8'h00; RSP_READY = 1'b0;
        @(negedge CLK);
        n_vec++; if (CMD_READY !== 1'b1 || BUSY !== 1'b0 || RSP_VALID !== 1'b0) begin n_err++; $display("FAIL rst_ctrl: got ready/busy/valid %b%b%b expected 100", CMD_READY, BUSY, RSP_VALID); end
        n_vec++; if (RF_CE !== 4'b0000 || RF_ADDR !== 2'd0 || RF_DATA_IN !== 8'h00 || RSP_DATA !== 8'h00) begin n_err++; $display("FAIL rst_data: got ce %b addr %0d din %h rsp %h expected all zero", RF_CE, RF_ADDR, RF_DATA_IN, RSP_DATA); end
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_directed();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] d;
            d = 8'(8'h11 * (i + 1));
            do_write(2'(i), d);
        end
        do_read(2'd2, 0);
        do_read(2'd2, 5);
        do_move(2'd3, 2'd0);
        do_read(2'd0, 0);
        do_read(2'd3, 0);
        do_swap(2'd1, 2'd2, 1'b0);
        do_read(2'd1, 0);
        do_read(2'd2, 0);
        do_swap(2'd1, 2'd1, 1'b0);
        do_read(2'd1, 0);
    endtask

    // Reset during SWAP c5: destination already written, source write lost.
    task automatic test_reset_mid_swap();
        do_swap(2'd1, 2'd2, 1'b1);
        RSTN = 1'b0;
        #1;
        n_vec++; if (RF_CE !== 4'b0000 || BUSY !== 1'b0 || CMD_READY !== 1'b1) begin n_err++; $display("FAIL rst_async: got ce %b busy %b ready %b expected 0000 0 1", RF_CE, BUSY, CMD_READY); end
        n_vec++; if (RSP_VALID !== 1'b0 || RF_ADDR !== 2'd0 || RF_DATA_IN !== 8'h00) begin n_err++; $display("FAIL rst_async_out: got valid %b addr %0d din %h expected 0 0 00", RSP_VALID, RF_ADDR, RF_DATA_IN); end
        @(negedge CLK);
        RSTN = 1'b1;
        @(negedge CLK);
        do_read(2'd1, 0);
        do_read(2'd2, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [1:0] s;
            logic [1:0] d;
            op = 2'($urandom_range(0, 3));
            s  = 2'($urandom_range(0, 3));
            d  = 2'($urandom_range(0, 3));
            case (op)
                OP_WRITE: do_write(d, 8'($urandom));
                OP_READ:  do_read(s, int'($urandom_range(0, 3)));
                OP_MOVE:  do_move(s, d);
                default:  do_swap(s, d, 1'b0);
            endcase
        end
        for (int r = 0; r < 4; r++) do_read(2'(r), 0);
    endtask

    // CMD_VALID held high across five commands; accepts counted at falling edges
    // where CMD_READY is seen high (accept happens at the next rising edge).
    task automatic test_back_to_back();
        logic [1:0] ops  [5];
        logic [1:0] dsts [5];
        logic [1:0] srcs [5];
        logic [7:0] d;
        logic [7:0] p0;
        int acc_cyc [5];
        int exp_gap [4];
        int nacc;
        int cyc;
        bit load_pending;
        logic [7:0] rsp_q [$];

        d  = 8'($urandom);
        p0 = model_regs[0];
        ops  = '{OP_WRITE, OP_READ, OP_MOVE, OP_SWAP, OP_READ};
        dsts = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd0};
        srcs = '{2'd0, 2'd3, 2'd3, 2'd1, 2'd0};
        exp_gap = '{2, 4, 4, 6};
        nacc = 0; cyc = 0; load_pending = 1'b0;

        CMD_OP = ops[0]; CMD_DST = dsts[0]; CMD_SRC = srcs[0]; CMD_DATA = d;
        CMD_VALID = 1'b1;
        RSP_READY = 1'b1;
        while (nacc < 5 && cyc < 200) begin
            if (load_pending) begin
                CMD_OP = ops[nacc]; CMD_DST = dsts[nacc]; CMD_SRC = srcs[nacc]; CMD_DATA = 8'h00;
                load_pending = 1'b0;
            end
            if (RSP_VALID === 1'b1) rsp_q.push_back(RSP_DATA);
            if (CMD_READY === 1'b1) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                load_pending = 1'b1;
            end
            @(negedge CLK);
            cyc++;
        end
        CMD_VALID = 1'b0;
        for (int k = 0; k < 20 && rsp_q.size() < 2; k++) begin
            if (RSP_VALID === 1'b1) rsp_q.push_back(RSP_DATA);
            @(negedge CLK);
        end
        for (int k = 0; k < 20 && CMD_READY !== 1'b1; k++) @(negedge CLK);
        RSP_READY = 1'b0;

        n_vec++; if (nacc != 5) begin n_err++; $display("FAIL b2b_accepts: got %0d expected 5", nacc); end
        for (int i = 0; i < 4; i++) begin
            if (i + 1 < nacc) begin
                n_vec++; if (acc_cyc[i+1] - acc_cyc[i] != exp_gap[i]) begin n_err++; $display("FAIL b2b_gap%0d: got %0d expected %0d", i, acc_cyc[i+1] - acc_cyc[i], exp_gap[i]); end
            end
        end
        n_vec++; if (rsp_q.size() != 2) begin n_err++; $display("FAIL b2b_rsp_count: got %0d expected 2", rsp_q.size()); end
        for (int i = 0; i < rsp_q.size() && i < 2; i++) begin
            n_vec++; if (rsp_q[i] !== d) begin n_err++; $display("FAIL b2b_rsp%0d: got %h expected %h", i, rsp_q[i], d); end
        end
        n_vec++; if (CMD_READY !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got CMD_READY %b expected 1", CMD_READY); end

        // WRITE r3=d; MOVE r1<=r3; SWAP r0<->r1.
        model_regs[3] = d;
        model_regs[0] = d;
        model_regs[1] = p0;
        for (int r = 0; r < 4; r++) do_read(2'(r), 0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) model_regs[i] = 8'h00;
        test_reset();
        test_directed();
        test_reset_mid_swap();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
